key_operand_loader: RTL and testbench

- Upstream stage for the 8-bit switch register and hex display path.
- Takes a raw pushbutton and the switch bus.
- Synchronises and debounces the button, then turns each press into a single-cycle load pulse.
- Sequences captures into two operand registers (A, then B), which feed the downstream register/display and arithmetic stages.

---
 rtl/key_operand_loader_pkg.sv | 10 +
 rtl/key_operand_loader_debounce.sv | 42 ++++
 rtl/key_operand_loader.sv | 65 ++++++
 tb/tb_key_operand_loader.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/key_operand_loader_pkg.sv
// key_operand_loader_pkg: state encodings and default sizing shared by the key loader and its bench.
package key_operand_loader_pkg;
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_HAVE_A = 2'b01;
    localparam logic [1:0] ST_HAVE_B = 2'b10;
    localparam int DEF_WIDTH           = 8;
    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_CNT_W           = 20;
    localparam int SIM_DEBOUNCE        = 4;
endpackage

// File: rtl/key_operand_loader_debounce.sv
// key_debounce: synchronises and debounces an active-low key, emitting one registered pulse per press.
module key_debounce
    import key_operand_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_press
);
    logic [1:0]       r_sync;
    logic             r_stable;
    logic             r_stable_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;
    logic             w_diff;
    logic             w_done;

    assign w_diff  = r_sync[1] != r_stable;
    assign w_done  = w_diff && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign o_press = r_press;

    // r_stable_q delays the accepted level so the press pulse lands one edge after the fall
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync     <= 2'b11;
            r_stable   <= 1'b1;
            r_stable_q <= 1'b1;
            r_cnt      <= '0;
            r_press    <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], i_key_n};
            r_stable_q <= r_stable;
            r_press    <= r_stable_q & ~r_stable;
            r_cnt      <= (!w_diff || w_done) ? '0 : r_cnt + 1'b1;
            if (w_done)
                r_stable <= r_sync[1];
        end
    end
endmodule

// File: rtl/key_operand_loader.sv
// key_operand_loader: turns debounced key presses into alternating A/B operand captures from the switches.
module key_operand_loader
    import key_operand_loader_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_sw,
    input  logic             i_key_n,
    output logic [WIDTH-1:0] o_op_a,
    output logic [WIDTH-1:0] o_op_b,
    output logic             o_a_valid,
    output logic             o_b_valid,
    output logic             o_load_pulse,
    output logic [1:0]       o_state
);
    logic             w_press;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic             r_a_valid;
    logic             r_b_valid;
    logic [1:0]       r_state;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_key_n(i_key_n),
        .o_press(w_press)
    );

    assign o_op_a       = r_op_a;
    assign o_op_b       = r_op_b;
    assign o_a_valid    = r_a_valid;
    assign o_b_valid    = r_b_valid;
    assign o_load_pulse = w_press;
    assign o_state      = r_state;

    // IDLE and HAVE_B both start a new pair in A; only HAVE_B has a stale B to invalidate
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_a_valid <= 1'b0;
            r_b_valid <= 1'b0;
            r_state   <= ST_IDLE;
        end else if (r_state == 2'b11) begin
            r_state <= ST_IDLE;
        end else if (w_press) begin
            if (r_state == ST_HAVE_A) begin
                r_op_b    <= i_sw;
                r_b_valid <= 1'b1;
                r_state   <= ST_HAVE_B;
            end else begin
                r_op_a    <= i_sw;
                r_a_valid <= 1'b1;
                r_state   <= ST_HAVE_A;
                if (r_state == ST_HAVE_B)
                    r_b_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_key_operand_loader.sv
// tb_key_operand_loader: scoreboard bench for debounce timing and A/B operand sequencing.
module tb_key_operand_loader;
    import key_operand_loader_pkg::*;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       av;
        logic       bv;
        logic [1:0] st;
    } obs_t;
    typedef struct {
        logic [7:0] sw;
        obs_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_n = 1'b1;
    logic [7:0] sw = 8'h00;
    logic [7:0] op_a, op_b;
    logic       a_valid, b_valid, load_pulse;
    logic [1:0] state;
    int         checks = 0;
    int         errors = 0;
    int         pulses = 0;
    int         p0;
    logic       seen = 1'b0;
    obs_t       exp_q[$];
    vec_t       vt[3];

    key_operand_loader #(.WIDTH(8), .DEBOUNCE_CYCLES(SIM_DEBOUNCE), .CNT_W(20)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_sw        (sw),
        .i_key_n     (key_n),
        .o_op_a      (op_a),
        .o_op_b      (op_b),
        .o_a_valid   (a_valid),
        .o_b_valid   (b_valid),
        .o_load_pulse(load_pulse),
        .o_state     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic obs_t obs();
        return {op_a, op_b, a_valid, b_valid, state};
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_op_a"}, op_a, 0);
        check({tag, "_op_b"}, op_b, 0);
        check({tag, "_a_valid"}, a_valid, 0);
        check({tag, "_b_valid"}, b_valid, 0);
        check({tag, "_pulse"}, load_pulse, 0);
        check({tag, "_state"}, state, ST_IDLE);
    endtask

    task automatic pulse_timing(input string tag);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            @(negedge clk);
            check(tag, load_pulse, (i == 6) ? 1 : 0);
        end
    endtask

    task automatic press(input logic [7:0] sw0, input logic [7:0] swc, input obs_t e, input int hold);
        sw = sw0;
        key_n = 1'b0;
        exp_q.push_back(e);
        cyc(7);
        sw = swc;
        cyc(hold);
        key_n = 1'b1;
        cyc(12);
    endtask

    // the edge after a pulse is the capture edge; any capture with nothing queued is spurious
    always @(negedge clk) begin
        if (seen) begin
            check("capture_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0)
                check("capture", obs(), exp_q.pop_front());
        end
        seen = load_pulse;
        if (load_pulse)
            pulses++;
    end

    initial begin
        vt[0] = '{8'h23, '{8'h23, 8'h00, 1'b1, 1'b0, ST_HAVE_A}};
        vt[1] = '{8'h59, '{8'h23, 8'h59, 1'b1, 1'b1, ST_HAVE_B}};
        vt[2] = '{8'h7A, '{8'h7A, 8'h59, 1'b1, 1'b0, ST_HAVE_A}};

        cyc(3);
        check_reset_outputs("init");
        rst = 1'b0;
        cyc(2);

        sw = 8'h23;
        key_n = 1'b0;
        exp_q.push_back('{8'h23, 8'h00, 1'b1, 1'b0, ST_HAVE_A});
        pulse_timing("clean_pulse_edge");
        cyc(20);
        key_n = 1'b1;
        cyc(12);
        check("clean_op_a", op_a, 8'h23);
        check("clean_state", state, ST_HAVE_A);
        check("clean_one_pulse", pulses, 1);

        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(2);

        p0 = pulses;
        key_n = 1'b0;
        cyc(3);
        key_n = 1'b1;
        cyc(1);
        key_n = 1'b0;
        cyc(3);
        key_n = 1'b1;
        cyc(12);
        check("bounce_no_pulse", pulses, p0);
        check("bounce_state", state, ST_IDLE);
        check("bounce_cnt", dut.u_deb.r_cnt, 0);

        for (int i = 0; i < 3; i++) begin
            press(vt[i].sw, vt[i].sw, vt[i].exp, 5);
            check("seq_hold", obs(), vt[i].exp);
        end

        p0 = pulses;
        sw = 8'h5C;
        key_n = 1'b0;
        cyc(4);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        check("held_no_pulse", pulses, p0);
        check("held_state", state, ST_IDLE);
        check("held_op_a", op_a, 0);
        exp_q.push_back('{8'h5C, 8'h00, 1'b1, 1'b0, ST_HAVE_A});
        pulse_timing("held_pulse_edge");
        cyc(3);
        key_n = 1'b1;
        cyc(12);

        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        cyc(2);
        press(8'h11, 8'h44, '{8'h44, 8'h00, 1'b1, 1'b0, ST_HAVE_A}, 3);
        check("swchg_op_a", op_a, 8'h44);

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
